// File: rtl/inst_queue.sv
// inst_queue: show-ahead instruction FIFO between fetch and decode.
// A rollback flushes it, and rdy low freezes all state.
module inst_queue #(
   parameter int IQ_SIZE  = 16,
   parameter int IQ_PTR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        IF_input_valid,
   input  logic [31:0] IF_inst,
   input  logic [31:0] IF_pc,
   input  logic        IF_pred_jump,
   output logic        IF_full,
   input  logic        ID_ready,
   output logic        ID_output_valid,
   output logic [31:0] ID_inst,
   output logic [31:0] ID_pc,
   output logic        ID_pred_jump,
   input  logic        ROB_rollback
);
   localparam logic [IQ_PTR_W:0] FULL_CNT = IQ_SIZE[IQ_PTR_W:0];
   logic [31:0]         mem_inst [IQ_SIZE];
   logic [31:0]         mem_pc   [IQ_SIZE];
   logic                mem_pj   [IQ_SIZE];
   logic [IQ_PTR_W-1:0] head, tail;
   logic [IQ_PTR_W:0]   count;
   logic                push, pop;
   assign IF_full         = count == FULL_CNT;
   assign ID_output_valid = count != '0;
   assign ID_inst         = mem_inst[head];
   assign ID_pc           = mem_pc[head];
   assign ID_pred_jump    = mem_pj[head];
   // full is judged on registered count, so a same-cycle pop never admits a push
   assign push = rst && rdy && IF_input_valid && !IF_full && !ROB_rollback;
   assign pop  = rst && rdy && ID_output_valid && ID_ready && !ROB_rollback;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy) begin
         if (ROB_rollback) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[tail] <= IF_inst;
         mem_pc[tail]   <= IF_pc;
         mem_pj[tail]   <= IF_pred_jump;
      end
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized and directed checks of inst_queue against a queue-based model.
module tb_inst_queue;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pj;
   } ent_t;
   logic        clk = 0, rst = 0, rdy = 0;
   logic        IF_input_valid = 0, IF_pred_jump = 0, IF_full;
   logic [31:0] IF_inst = 0, IF_pc = 0;
   logic        ID_ready = 0, ID_output_valid, ID_pred_jump, ROB_rollback = 0;
   logic [31:0] ID_inst, ID_pc;
   int          n_chk = 0, n_fail = 0;
   ent_t        q[$];
   inst_queue dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .IF_input_valid(IF_input_valid), .IF_inst(IF_inst), .IF_pc(IF_pc),
      .IF_pred_jump(IF_pred_jump), .IF_full(IF_full),
      .ID_ready(ID_ready), .ID_output_valid(ID_output_valid),
      .ID_inst(ID_inst), .ID_pc(ID_pc), .ID_pred_jump(ID_pred_jump),
      .ROB_rollback(ROB_rollback)
   );
   always #5 clk = ~clk;
   // drive one cycle of stimulus, take the edge, then advance the model
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pj, input logic rd, input logic rb, input logic en);
      bit pu, po;
      IF_input_valid = v; IF_inst = inst; IF_pc = pc; IF_pred_jump = pj;
      ID_ready = rd; ROB_rollback = rb; rdy = en;
      pu = v && q.size() < 16;
      po = rd && q.size() > 0;
      @(posedge clk); #1;
      if (en) begin
         if (rb) q.delete();
         else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back('{inst: inst, pc: pc, pj: pj});
         end
      end
   endtask
   task automatic test_reset();
      rst = 0; #1;
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ID_output_valid); end
      n_chk++; if (IF_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", IF_full); end
      q.delete();
      @(negedge clk); rst = 1;
   endtask
   task automatic test_single();
      step(1, 32'h13, 32'h0, 0, 0, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", ID_output_valid); end
      n_chk++; if (ID_inst !== 32'h13) begin n_fail++; $display("FAIL single_inst got %h want 00000013", ID_inst); end
      n_chk++; if (ID_pc !== 32'h0) begin n_fail++; $display("FAIL single_pc got %h want 0", ID_pc); end
      n_chk++; if (IF_full !== 1'b0) begin n_fail++; $display("FAIL single_full got %b want 0", IF_full); end
      step(0, 0, 0, 0, 1, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", ID_output_valid); end
   endtask
   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (IF_full !== 1'b0) begin n_fail++; $display("FAIL fill_early_full i=%0d got %b want 0", i, IF_full); end
         step(1, $urandom, i * 4, 0, 0, 0, 1);
      end
      n_chk++; if (IF_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", IF_full); end
      step(1, 32'hBAD, 32'h40, 0, 0, 0, 1);
      n_chk++; if (IF_full !== 1'b1) begin n_fail++; $display("FAIL fill_drop_full got %b want 1", IF_full); end
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (ID_output_valid !== 1'b1 || ID_pc !== i * 4) begin n_fail++; $display("FAIL fill_order i=%0d got v=%b pc=%h want v=1 pc=%h", i, ID_output_valid, ID_pc, i * 4); end
         n_chk++; if (ID_inst !== q[0].inst) begin n_fail++; $display("FAIL fill_inst i=%0d got %h want %h", i, ID_inst, q[0].inst); end
         step(0, 0, 0, 0, 1, 0, 1);
      end
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", ID_output_valid); end
   endtask
   task automatic test_full_push_pop();
      int pops;
      for (int i = 0; i < 16; i++) step(1, $urandom, 32'h100 + i * 4, 0, 0, 0, 1);
      step(1, 32'hDEAD, 32'hDEAD, 1, 1, 0, 1);
      n_chk++; if (IF_full !== 1'b0) begin n_fail++; $display("FAIL fpp_full got %b want 0", IF_full); end
      pops = 0;
      for (int i = 0; i < 20 && ID_output_valid === 1'b1; i++) begin
         n_chk++; if (ID_pc !== 32'h104 + pops * 4) begin n_fail++; $display("FAIL fpp_order got %h want %h", ID_pc, 32'h104 + pops * 4); end
         step(0, 0, 0, 0, 1, 0, 1);
         pops++;
      end
      n_chk++; if (pops != 15) begin n_fail++; $display("FAIL fpp_count got %0d want 15", pops); end
   endtask
   task automatic test_wrap();
      logic [31:0] exp_pc[$];
      logic        exp_pj[$];
      logic        pj;
      for (int i = 0; i < 10; i++) begin
         pj = $urandom_range(0, 1); exp_pc.push_back(32'h200 + i * 4); exp_pj.push_back(pj);
         step(1, $urandom, 32'h200 + i * 4, pj, 0, 0, 1);
      end
      for (int i = 0; i < 8; i++) begin
         void'(exp_pc.pop_front()); void'(exp_pj.pop_front());
         step(0, 0, 0, 0, 1, 0, 1);
      end
      for (int i = 10; i < 22; i++) begin
         pj = $urandom_range(0, 1); exp_pc.push_back(32'h200 + i * 4); exp_pj.push_back(pj);
         step(1, $urandom, 32'h200 + i * 4, pj, 0, 0, 1);
      end
      n_chk++; if (exp_pc.size() != 14 || IF_full !== 1'b0) begin n_fail++; $display("FAIL wrap_setup got full=%b want 0", IF_full); end
      while (exp_pc.size() > 0) begin
         n_chk++; if (ID_output_valid !== 1'b1 || ID_pc !== exp_pc[0] || ID_pred_jump !== exp_pj[0] || ID_inst !== q[0].inst)
            begin n_fail++; $display("FAIL wrap_order got v=%b pc=%h pj=%b want pc=%h pj=%b", ID_output_valid, ID_pc, ID_pred_jump, exp_pc[0], exp_pj[0]); end
         void'(exp_pc.pop_front()); void'(exp_pj.pop_front());
         step(0, 0, 0, 0, 1, 0, 1);
      end
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", ID_output_valid); end
   endtask
   task automatic test_rollback();
      for (int i = 0; i < 5; i++) step(1, $urandom, 32'h300 + i * 4, 0, 0, 0, 1);
      step(1, 32'h77, 32'h777, 0, 1, 1, 1);
      n_chk++; if (ID_output_valid !== 1'b0 || IF_full !== 1'b0) begin n_fail++; $display("FAIL rb_clear got v=%b full=%b want 0 0", ID_output_valid, IF_full); end
      step(1, 32'h55, 32'h400, 1, 0, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b1 || ID_pc !== 32'h400 || ID_inst !== 32'h55 || ID_pred_jump !== 1'b1)
         begin n_fail++; $display("FAIL rb_push got v=%b pc=%h inst=%h pj=%b want 1 400 55 1", ID_output_valid, ID_pc, ID_inst, ID_pred_jump); end
      step(0, 0, 0, 0, 1, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL rb_alone got %b want 0", ID_output_valid); end
   endtask
   task automatic test_rdy_freeze();
      for (int i = 0; i < 3; i++) step(1, $urandom, 32'h500 + i * 4, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, $urandom, 32'h900, 0, 1, i == 2, 0);
         n_chk++; if (ID_output_valid !== 1'b1 || ID_pc !== 32'h500) begin n_fail++; $display("FAIL freeze_head c=%0d got v=%b pc=%h want 1 500", i, ID_output_valid, ID_pc); end
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (ID_pc !== 32'h500 + i * 4) begin n_fail++; $display("FAIL freeze_count i=%0d got %h want %h", i, ID_pc, 32'h500 + i * 4); end
         step(0, 0, 0, 0, 1, 0, 1);
      end
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_empty got %b want 0", ID_output_valid); end
      step(1, $urandom, 32'h600, 0, 0, 0, 1);
      step(1, $urandom, 32'h604, 0, 0, 0, 1);
      #2 rst = 0; #1;
      n_chk++; if (ID_output_valid !== 1'b0 || IF_full !== 1'b0) begin n_fail++; $display("FAIL async_rst got v=%b full=%b want 0 0", ID_output_valid, IF_full); end
      q.delete();
      step(1, $urandom, 32'h700, 0, 0, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b0) begin n_fail++; $display("FAIL rst_suppress got %b want 0", ID_output_valid); end
      q.delete();
      @(negedge clk); rst = 1;
      step(1, 32'h13, 32'h800, 0, 0, 0, 1);
      n_chk++; if (ID_output_valid !== 1'b1 || ID_pc !== 32'h800) begin n_fail++; $display("FAIL post_rst got v=%b pc=%h want 1 800", ID_output_valid, ID_pc); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1),
              $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0);
         n_chk++; if (ID_output_valid !== (q.size() != 0) || IF_full !== (q.size() == 16))
            begin n_fail++; $display("FAIL rand_flags c=%0d got v=%b full=%b want size %0d", i, ID_output_valid, IF_full, q.size()); end
         if (q.size() != 0) begin
            n_chk++; if ({ID_inst, ID_pc, ID_pred_jump} !== q[0])
               begin n_fail++; $display("FAIL rand_head c=%0d got %h %h %b want %h %h %b", i, ID_inst, ID_pc, ID_pred_jump, q[0].inst, q[0].pc, q[0].pj); end
         end
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_push_pop();
      test_wrap();
      test_rollback();
      test_rdy_freeze();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter IQ_SIZE, default 16, entry count (power of two).
REQ-002 The block SHALL have parameter IQ_PTR_W, default 4, log2(IQ_SIZE).
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port rdy, input, 1: global enable; when low, all state frozen.
REQ-006 The block SHALL have port IF_input_valid, input, 1: fetcher presents an instruction this cycle.
REQ-007 The block SHALL have port IF_inst, input, `InstWidth (32): instruction word.
REQ-008 The block SHALL have port IF_pc, input, `AddrWidth (32): instruction address.
REQ-009 The block SHALL have port IF_pred_jump, input, 1: predictor's taken decision for this instruction.
REQ-010 The block SHALL have port IF_full, output, 1: queue cannot accept a push this cycle.
REQ-011 The block SHALL have port ID_ready, input, 1: decoder consumes the head entry this cycle.
REQ-012 The block SHALL have port ID_output_valid, output, 1: head entry present.
REQ-013 The block SHALL have port ID_inst, output, 32: head instruction.
REQ-014 The block SHALL have port ID_pc, output, 32: head address.
REQ-015 The block SHALL have port ID_pred_jump, output, 1: head predicted-taken flag.
REQ-016 The block SHALL have port ROB_rollback, input, 1: misprediction flush.

Function
REQ-017 Storage: IQ_SIZE entries of {inst 32, pc 32, pred_jump 1}; head/tail pointers IQ_PTR_W bits, count IQ_PTR_W+1 bits.
REQ-018 Push = rdy & IF_input_valid & ~IF_full & ~ROB_rollback; writes entry at tail, tail+1.
REQ-019 Pop = rdy & ID_output_valid & ID_ready & ~ROB_rollback; head+1.
REQ-020 Pointers wrap IQ_SIZE-1 -> 0 by natural IQ_PTR_W-bit overflow.
REQ-021 Count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 IF_full = (count == IQ_SIZE), registered-state derived; a same-cycle pop does not lift full (push while full is dropped, not queued).
REQ-023 Push with IF_full high: ignored, contents unchanged; fetcher holds instruction.
REQ-024 Outputs show-ahead: ID_inst/ID_pc/ID_pred_jump driven combinationally from entry[head]; ID_output_valid = (count != 0).
REQ-025 Latency: instruction pushed at edge N visible on ID_* after edge N (one cycle) when queue was empty; no bypass from IF_* to ID_*.
REQ-026 ID_ready with count==0: no effect, no underflow.
REQ-027 Simultaneous push and pop at count 1..IQ_SIZE-1: both occur, count unchanged, order preserved (FIFO).
REQ-028 ROB_rollback (when rdy high): head, tail, count cleared to 0 at that edge; concurrent push and pop discarded; ID_output_valid low next cycle.
REQ-029 rdy low: no push, no pop, no rollback effect; outputs reflect held state.
REQ-030 ID_* payload when ID_output_valid low is don't-care; verification SHALL NOT check it.

Reset
REQ-031 rst low asynchronously clears head, tail, count to 0; ID_output_valid=0, IF_full=0 immediately.
REQ-032 Entry storage not reset.
REQ-033 Reset asserted mid-operation discards all entries; first push after release lands at index 0.
REQ-034 Pushes/pops are suppressed while rst is low.

Verification
REQ-035 Reset, then push inst 0x00000013 at pc 0x00000000, pred_jump 0 -> next cycle ID_output_valid=1, ID_inst=0x00000013, ID_pc=0x0, IF_full=0.
REQ-036 16 pushes pc 0x0,0x4..0x3C with ID_ready=0 -> IF_full=1 after 16th; 17th push (pc 0x40) dropped; then pop 16 -> pcs 0x0..0x3C in order, ID_output_valid=0 after last.
REQ-037 At count 16, IF_input_valid=1 and ID_ready=1 same cycle -> pop occurs, push dropped, count 15, IF_full=0 next cycle.
REQ-038 Fill 10 entries, pop 8, push 12 (tail wraps 15->0) -> 14 entries drained in exact push order, pred_jump flags preserved.
REQ-039 Count 5, assert ROB_rollback with IF_input_valid=1 and ID_ready=1 -> next cycle count 0, ID_output_valid=0; subsequent push appears alone.
REQ-040 Count 3, hold rdy=0 for 4 cycles with IF_input_valid=1, ID_ready=1 -> count stays 3, head unchanged; rst pulse low mid-run -> ID_output_valid=0 immediately, without clock edge.
